// File: rtl/fir2d_pkg.sv
// Shared types and helpers for the 2D FIR line-buffer sequencing logic.
package fir2d_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLR   = 3'd1,
        ST_PRIME = 3'd2,
        ST_RUN   = 3'd3,
        ST_DONE  = 3'd4
    } lbc_state_t;

    localparam int IMG_W_DEF = 32;
    localparam int IMG_H_DEF = 32;
    localparam int COL_W     = $clog2(IMG_W_DEF);
    localparam int ROW_W     = $clog2(IMG_H_DEF);

    // Number of valid-only windows produced by one frame.
    function automatic int win_count(input int img_w, input int img_h, input int taps);
        return (img_w - taps + 1) * (img_h - taps + 1);
    endfunction

endpackage

// File: rtl/xy_counter.sv
// Raster column/row position counter that wraps at end of line and end of frame.
module xy_counter #(
    parameter int W  = 32,
    parameter int H  = 32,
    parameter int CW = 5,
    parameter int RW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_i,
    input  logic          en_i,
    output logic [CW-1:0] col_o,
    output logic [RW-1:0] row_o,
    output logic          eol_o,
    output logic          eof_o
);

    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;

    assign col_o = col_q;
    assign row_o = row_q;
    assign eol_o = (col_q == CW'(W - 1));
    assign eof_o = eol_o && (row_q == RW'(H - 1));

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (clr_i) begin
            col_d = '0;
            row_d = '0;
        end else if (en_i) begin
            if (eol_o) begin
                col_d = '0;
                row_d = eof_o ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end else begin
            col_d = col_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

endmodule

// File: rtl/line_buf_ctrl.sv
// Sequencer for the TAPS-1 line FIFO cascade: FIFO strobes, window-valid flags,
// frame status and sticky FIFO misuse detection.
module line_buf_ctrl
    import fir2d_pkg::*;
#(
    parameter int IMG_W      = 32,
    parameter int IMG_H      = 32,
    parameter int TAPS       = 5,
    parameter int FIFO_DEPTH = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            s_valid,
    output logic            s_ready,
    input  logic            m_ready,
    output logic [TAPS-2:0] fifo_wr,
    output logic [TAPS-2:0] fifo_rd,
    output logic            fifo_rst,
    input  logic [TAPS-2:0] fifo_full,
    input  logic [TAPS-2:0] fifo_empty,
    output logic            win_valid,
    output logic            win_last,
    output logic            busy,
    output logic            done,
    output logic            err_ovf,
    output logic            err_unf
);

    localparam int CW = (IMG_W == IMG_W_DEF) ? COL_W : $clog2(IMG_W);
    localparam int RW = (IMG_H == IMG_H_DEF) ? ROW_W : $clog2(IMG_H);
    localparam int NF = TAPS - 1;

    // A line must fit in one FIFO or the cascade loses pixels.
    if (FIFO_DEPTH < IMG_W) begin : g_depth_check
        $error("line_buf_ctrl: FIFO_DEPTH smaller than IMG_W");
    end

    lbc_state_t    state_q, state_d;
    logic [CW-1:0] col_s;
    logic [RW-1:0] row_s;
    logic          eol_s, eof_s, acc_s, abort_s, win_d, last_d;
    logic [NF-1:0] wr_s, rd_s;
    logic          fifo_rst_q, busy_q, done_q, win_valid_q, win_last_q, err_ovf_q, err_unf_q;

    assign s_ready  = ((state_q == ST_PRIME) || (state_q == ST_RUN)) && m_ready;
    assign acc_s    = s_valid && s_ready;
    assign abort_s  = start && ((state_q == ST_PRIME) || (state_q == ST_RUN) || (state_q == ST_DONE));
    assign fifo_wr  = wr_s;
    assign fifo_rd  = rd_s;
    assign fifo_rst = fifo_rst_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign win_valid = win_valid_q;
    assign win_last  = win_last_q;
    assign err_ovf  = err_ovf_q;
    assign err_unf  = err_unf_q;

    xy_counter #(.W(IMG_W), .H(IMG_H), .CW(CW), .RW(RW)) u_xy (
        .clk   (clk),
        .rst   (rst),
        .clr_i (state_q == ST_CLR),
        .en_i  (acc_s),
        .col_o (col_s),
        .row_o (row_s),
        .eol_o (eol_s),
        .eof_o (eof_s)
    );

    // FIFO i holds the line i+1 rows up, so it starts filling at row i and draining at row i+1.
    always_comb begin
        wr_s = '0;
        rd_s = '0;
        for (int i = 0; i < NF; i++) begin
            wr_s[i] = acc_s && (int'(row_s) >= i);
            rd_s[i] = acc_s && (int'(row_s) >= i + 1);
        end
        win_d  = acc_s && !abort_s && (int'(row_s) >= TAPS - 1) && (int'(col_s) >= TAPS - 1);
        last_d = win_d && eof_s;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  state_d = start ? ST_CLR : ST_IDLE;
            ST_CLR:   state_d = ST_PRIME;
            ST_PRIME: begin
                if (abort_s) begin
                    state_d = ST_CLR;
                end else if (acc_s && eol_s && (row_s == RW'(TAPS - 2))) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_PRIME;
                end
            end
            ST_RUN: begin
                if (abort_s) begin
                    state_d = ST_CLR;
                end else if (acc_s && eof_s) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE:  state_d = abort_s ? ST_CLR : ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Status outputs are registered from the next state so they align with the state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            fifo_rst_q  <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            win_valid_q <= 1'b0;
            win_last_q  <= 1'b0;
            err_ovf_q   <= 1'b0;
            err_unf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            fifo_rst_q  <= (state_d == ST_CLR);
            busy_q      <= (state_d == ST_CLR) || (state_d == ST_PRIME) || (state_d == ST_RUN);
            done_q      <= (state_d == ST_DONE);
            win_valid_q <= win_d;
            win_last_q  <= last_d;
            err_ovf_q   <= err_ovf_q || (|(wr_s & ~rd_s & fifo_full));
            err_unf_q   <= err_unf_q || (|(rd_s & fifo_empty));
        end
    end

endmodule

// File: tb/tb_line_buf_ctrl.sv
// Self-checking bench for line_buf_ctrl against a pixel-index based frame model.
module tb_line_buf_ctrl;

    localparam int W  = 32;
    localparam int H  = 32;
    localparam int T  = 5;
    localparam int D  = 32;
    localparam int NF = T - 1;
    localparam int NWIN = (W - T + 1) * (H - T + 1);
    localparam int PH_IDLE = 0, PH_CLR = 1, PH_ACT = 2, PH_DONE = 3;

    logic clk = 1'b0;
    logic rst, start, s_valid, s_ready, m_ready, fifo_rst;
    logic win_valid, win_last, busy, done, err_ovf, err_unf;
    logic [NF-1:0] fifo_wr, fifo_rd, fifo_full, fifo_empty;

    int nvec = 0;
    int nerr = 0;
    int phase, pix, dut_wins, first_win, first_wr3, ovf_pix, unf_pix;
    logic e_ovf, e_unf;
    bit real_full;

    always #5 clk = ~clk;

    line_buf_ctrl #(.IMG_W(W), .IMG_H(H), .TAPS(T), .FIFO_DEPTH(D)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .m_ready    (m_ready),
        .fifo_wr    (fifo_wr),
        .fifo_rd    (fifo_rd),
        .fifo_rst   (fifo_rst),
        .fifo_full  (fifo_full),
        .fifo_empty (fifo_empty),
        .win_valid  (win_valid),
        .win_last   (win_last),
        .busy       (busy),
        .done       (done),
        .err_ovf    (err_ovf),
        .err_unf    (err_unf)
    );

    // One clock cycle: called at posedge+1, returns at the next posedge+1.
    task automatic step(input logic sv, input logic mr, input logic st);
        logic acc, e_win, e_last;
        int r, c, acc_pix;
        logic [NF-1:0] ewr, erd;
        r = pix / W;
        c = pix % W;
        s_valid = sv;
        m_ready = mr;
        start   = st;
        for (int i = 0; i < NF; i++) fifo_full[i] = real_full && (phase == PH_ACT) && (r >= i + 1);
        if (pix == ovf_pix && phase == PH_ACT) fifo_full[0] = 1'b1;
        fifo_empty = '0;
        if (pix == unf_pix && phase == PH_ACT) fifo_empty[2] = 1'b1;
        @(negedge clk);
        acc = sv && mr && (phase == PH_ACT);
        ewr = '0;
        erd = '0;
        for (int i = 0; i < NF; i++) begin
            ewr[i] = acc && (r >= i);
            erd[i] = acc && (r >= i + 1);
        end
        nvec++;
        if (s_ready !== (mr && phase == PH_ACT)) begin
            nerr++;
            $display("FAIL s_ready: got %b expected %b (pix %0d)", s_ready, mr && phase == PH_ACT, pix);
        end
        nvec++;
        if (fifo_wr !== ewr) begin
            nerr++;
            $display("FAIL fifo_wr: got %b expected %b (pix %0d)", fifo_wr, ewr, pix);
        end
        nvec++;
        if (fifo_rd !== erd) begin
            nerr++;
            $display("FAIL fifo_rd: got %b expected %b (pix %0d)", fifo_rd, erd, pix);
        end
        if (fifo_wr[3] === 1'b1 && first_wr3 < 0) first_wr3 = pix;
        for (int i = 0; i < NF; i++) begin
            if (ewr[i] && !erd[i] && fifo_full[i]) e_ovf = 1'b1;
            if (erd[i] && fifo_empty[i]) e_unf = 1'b1;
        end
        e_win  = 1'b0;
        e_last = 1'b0;
        acc_pix = pix;
        case (phase)
            PH_IDLE: if (st) phase = PH_CLR;
            PH_CLR:  phase = PH_ACT;
            PH_ACT: begin
                if (st) begin
                    phase = PH_CLR;
                end else if (acc) begin
                    e_win  = (r >= T - 1) && (c >= T - 1);
                    e_last = e_win && (pix == W * H - 1);
                    pix++;
                    if (pix == W * H) phase = PH_DONE;
                end
            end
            PH_DONE: phase = st ? PH_CLR : PH_IDLE;
            default: phase = PH_IDLE;
        endcase
        if (phase == PH_CLR) begin
            pix = 0;
            dut_wins = 0;
        end
        @(posedge clk);
        #1;
        if (win_valid === 1'b1) begin
            dut_wins++;
            if (first_win < 0) first_win = acc_pix;
        end
        nvec++;
        if (win_valid !== e_win) begin
            nerr++;
            $display("FAIL win_valid: got %b expected %b (pix %0d)", win_valid, e_win, acc_pix);
        end
        nvec++;
        if (win_last !== e_last) begin
            nerr++;
            $display("FAIL win_last: got %b expected %b (pix %0d)", win_last, e_last, acc_pix);
        end
        nvec++;
        if (done !== (phase == PH_DONE)) begin
            nerr++;
            $display("FAIL done: got %b expected %b", done, phase == PH_DONE);
        end
        nvec++;
        if (busy !== (phase == PH_CLR || phase == PH_ACT)) begin
            nerr++;
            $display("FAIL busy: got %b expected %b", busy, phase == PH_CLR || phase == PH_ACT);
        end
        nvec++;
        if (fifo_rst !== (phase == PH_CLR)) begin
            nerr++;
            $display("FAIL fifo_rst: got %b expected %b", fifo_rst, phase == PH_CLR);
        end
        nvec++;
        if (err_ovf !== e_ovf || err_unf !== e_unf) begin
            nerr++;
            $display("FAIL errors: got ovf=%b unf=%b expected ovf=%b unf=%b", err_ovf, err_unf, e_ovf, e_unf);
        end
    endtask

    task automatic model_reset();
        phase = PH_IDLE;
        pix   = 0;
        e_ovf = 1'b0;
        e_unf = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        start = 1'b0;
        s_valid = 1'b0;
        m_ready = 1'b0;
        fifo_full = '0;
        fifo_empty = '0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        nvec++;
        if (fifo_rst !== 1'b0 || err_ovf !== 1'b0 || err_unf !== 1'b0) begin
            nerr++;
            $display("FAIL post_reset: got fifo_rst=%b ovf=%b unf=%b expected 0 0 0", fifo_rst, err_ovf, err_unf);
        end
    endtask

    task automatic run_frame(input int mode, input int abort_pix, input int exp_wins);
        int budget;
        bit aborted;
        logic sv, mr, st;
        dut_wins = 0;
        aborted = 1'b0;
        step(1'b0, 1'b1, 1'b1);
        budget = 0;
        while (phase != PH_IDLE && budget < 20000) begin
            sv = (mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
            mr = (mode == 0) ? 1'b1 : ($urandom_range(0, 4) != 0);
            st = 1'b0;
            if (!aborted && abort_pix >= 0 && phase == PH_ACT && pix == abort_pix && sv && mr) begin
                st = 1'b1;
                aborted = 1'b1;
            end
            step(sv, mr, st);
            budget++;
        end
        nvec++;
        if (phase != PH_IDLE) begin
            nerr++;
            $display("FAIL frame_timeout: got %0d cycles expected frame end", budget);
        end
        nvec++;
        if (dut_wins !== exp_wins) begin
            nerr++;
            $display("FAIL window_count: got %0d expected %0d", dut_wins, exp_wins);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2;
        nvec++;
        if (fifo_rst !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || win_valid !== 1'b0 ||
            win_last !== 1'b0 || s_ready !== 1'b0 || fifo_wr !== '0 || fifo_rd !== '0 ||
            err_ovf !== 1'b0 || err_unf !== 1'b0) begin
            nerr++;
            $display("FAIL reset_values: got fifo_rst=%b busy=%b done=%b win=%b expected 1 0 0 0",
                     fifo_rst, busy, done, win_valid);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        nvec++;
        if (fifo_rst !== 1'b0) begin
            nerr++;
            $display("FAIL reset_release: got fifo_rst=%b expected 0", fifo_rst);
        end
        step(1'b0, 1'b1, 1'b1);
        repeat (5 * W + 12) step(1'b1, 1'b1, 1'b0);
        rst = 1'b1;
        #1;
        nvec++;
        if (fifo_rst !== 1'b1 || busy !== 1'b0 || win_valid !== 1'b0 || done !== 1'b0 ||
            s_ready !== 1'b0 || err_ovf !== 1'b0 || err_unf !== 1'b0) begin
            nerr++;
            $display("FAIL midframe_reset: got fifo_rst=%b busy=%b win=%b s_ready=%b expected 1 0 0 0",
                     fifo_rst, busy, win_valid, s_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        nvec++;
        if (fifo_rst !== 1'b0 || busy !== 1'b0) begin
            nerr++;
            $display("FAIL midframe_release: got fifo_rst=%b busy=%b expected 0 0", fifo_rst, busy);
        end
    endtask

    task automatic test_full_frame();
        apply_reset();
        real_full = 1'b1;
        first_win = -1;
        first_wr3 = -1;
        run_frame(0, -1, NWIN);
        real_full = 1'b0;
        nvec++;
        if (first_win !== 4 * W + 4) begin
            nerr++;
            $display("FAIL first_window: got pix %0d expected %0d", first_win, 4 * W + 4);
        end
        nvec++;
        if (first_wr3 !== 3 * W) begin
            nerr++;
            $display("FAIL first_wr3: got pix %0d expected %0d", first_wr3, 3 * W);
        end
    endtask

    task automatic test_stalls();
        apply_reset();
        run_frame(1, -1, NWIN);
        run_frame(1, -1, NWIN);
    endtask

    task automatic test_abort();
        apply_reset();
        run_frame(0, 10 * W + 7, NWIN);
    endtask

    task automatic test_overflow();
        apply_reset();
        ovf_pix = 5;
        run_frame(0, -1, NWIN);
        ovf_pix = -1;
        nvec++;
        if (err_ovf !== 1'b1) begin
            nerr++;
            $display("FAIL ovf_sticky: got %b expected 1", err_ovf);
        end
        step(1'b0, 1'b1, 1'b0);
        apply_reset();
    endtask

    task automatic test_underflow();
        unf_pix = 5 * W + 3;
        run_frame(0, -1, NWIN);
        unf_pix = -1;
        nvec++;
        if (err_unf !== 1'b1 || err_ovf !== 1'b0) begin
            nerr++;
            $display("FAIL unf_flags: got unf=%b ovf=%b expected 1 0", err_unf, err_ovf);
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        s_valid = 1'b0;
        m_ready = 1'b1;
        fifo_full = '0;
        fifo_empty = '0;
        real_full = 1'b0;
        ovf_pix = -1;
        unf_pix = -1;
        first_win = -1;
        first_wr3 = -1;
        dut_wins = 0;
        model_reset();
        test_reset();
        test_full_frame();
        test_stalls();
        test_abort();
        test_overflow();
        test_underflow();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/line_buf_ctrl.md
# line_buf_ctrl

Sequencing controller for the cascade of `TAPS-1` `srl_fifo` line buffers that feeds the 2D FIR window datapath. It accepts a raster pixel stream and tracks the column and row position. It drives per-FIFO write, read and clear strobes so that FIFO *i* always holds the line *i+1* rows above the current one. It flags when a complete `TAPS`×`TAPS` window (valid-only, no border padding) is present at the window registers, and detects FIFO misuse.

## Interface
- `IMG_W`, 32: pixels per line; 2..`FIFO_DEPTH`.
- `IMG_H`, 32: lines per frame; ≥ `TAPS`.
- `TAPS`, 5: window size; 2..16; sets the number of line FIFOs (`TAPS-1`).
- `FIFO_DEPTH`, 32: depth of each attached `srl_fifo`; ≥ `IMG_W`.
- `clk` in 1: single clock; all logic is on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle pulse that (re)starts a frame.
- `s_valid` in 1: an input pixel is present.
- `s_ready` out 1: controller accepts the pixel; a pixel is accepted ("acc") when `s_valid & s_ready`.
- `m_ready` in 1: downstream window datapath can advance.
- `fifo_wr` out `TAPS-1`: per-FIFO write strobe.
- `fifo_rd` out `TAPS-1`: per-FIFO read strobe.
- `fifo_rst` out 1: synchronous clear to all line FIFOs.
- `fifo_full` in `TAPS-1`: per-FIFO `full` flag.
- `fifo_empty` in `TAPS-1`: per-FIFO `empty` flag.
- `win_valid` out 1: window registers hold a complete window.
- `win_last` out 1: qualifies the final window of the frame.
- `busy` out 1: a frame is in progress.
- `done` out 1: one-cycle pulse at end of frame.
- `err_ovf` out 1: sticky overflow error.
- `err_unf` out 1: sticky underflow error.

## Operation
- **States and transitions:**
  - `IDLE` → `CLR` on `start`.
  - `CLR` → `PRIME` after 1 cycle.
  - `PRIME` → `RUN` when a pixel is accepted with `col==IMG_W-1` and `row==TAPS-2`.
  - `RUN` → `DONE` when a pixel is accepted with `col==IMG_W-1` and `row==IMG_H-1`.
  - `DONE` → `IDLE` after 1 cycle.
- **`start` in `PRIME`, `RUN` or `DONE`:** aborts the frame and goes to `CLR`. `col`, `row` and the window state are discarded. The error flags are kept.
- **`start` in `CLR`:** ignored.
- **Counters:** `col` runs 0..`IMG_W-1` and wraps to 0 while incrementing `row`. `row` runs 0..`IMG_H-1`. Both are cleared in `CLR` and advance only on acc. Widths are `$clog2` of the limit, with no overflow.
- **`s_ready`:** `(state==PRIME || state==RUN) & m_ready`. It is combinational from state and `m_ready`.
- **`fifo_wr[i]`:** `acc & (row >= i)`. Combinational, same cycle as acc.
- **`fifo_rd[i]`:** `acc & (row >= i+1)`. Combinational, same cycle as acc. FIFO *i*'s `q` is consumed by the window datapath and by FIFO *i+1*'s `d` on that edge.
- **`fifo_rst`:** 1 in `CLR`, 0 otherwise.
- **`win_valid`:** registered; set on the edge of an acc with `row >= TAPS-1` and `col >= TAPS-1`, otherwise cleared.
- **`win_last`:** registered; set with `win_valid` when that acc is the frame's last pixel.
- **`busy`:** 1 in `CLR`, `PRIME` and `RUN`.
- **`done`:** 1 in `DONE`.
- **`err_ovf`:** set when any `fifo_wr[i] & ~fifo_rd[i] & fifo_full[i]`.
- **`err_unf`:** set when any `fifo_rd[i] & fifo_empty[i]`.
- **Clearing the error flags:** both are cleared only by `rst`. They do not block operation.
- **Boundary conditions:**
  - With `FIFO_DEPTH==IMG_W`, a FIFO is full in steady state with simultaneous rd/wr. This is legal and is not an overflow.
  - `s_valid` outside `PRIME`/`RUN` is ignored.
  - `m_ready` low freezes all counters and strobes.
  - `win_valid` is not held across stalls; it is a one-cycle pulse per acc.

## Timing
- **Reset values:**
  - `fifo_rst`=1; all other outputs 0.
  - State is `IDLE`; counters are 0.
  - `fifo_rst` drops on the first clock edge after `rst` deasserts.
- **`start` to first acceptance:** `start` at edge *n* gives `CLR` in cycle *n+1* and `s_ready` possible from cycle *n+2*.
- **`win_valid` latency:** 1 cycle after the acc of the window's bottom-right pixel.
- **Steady state:** one pixel and one window per cycle with `m_ready` and `s_valid` held high.
- **`done`:** asserted the cycle after the last acc, coincident with `win_last`.
- **`IMG_H`×`IMG_W` frame:** `(IMG_W-TAPS+1)*(IMG_H-TAPS+1)` `win_valid` pulses.

## Structure
- **Package `fir2d_pkg`:**
  - state enum `lbc_state_t`.
  - localparams `COL_W=$clog2(IMG_W)` and `ROW_W=$clog2(IMG_H)`.
  - window-count helper function.
- **Sub-module `xy_counter`:** the parameterised column/row wrap counter with `clr`, `en`, `col`, `row`, `eol` and `eof`.
- **Not instantiated here:** the `srl_fifo` instances and window registers live in the parent.

## Test plan
- **Reset:** `rst` high mid-frame → immediately `fifo_rst`=1, `busy`/`win_valid`/`done`/errors 0, `s_ready`=0. First edge after release → `fifo_rst`=0.
- **Full frame:** defaults, `start`, then 1024 back-to-back pixels with `m_ready`=1 → exactly 784 `win_valid`, first one the cycle after the pixel at row 4, col 4. `win_last` and `done` the cycle after pixel 1023. `fifo_wr[3]` first asserts at row 3.
- **Stalls:** random `m_ready`/`s_valid` gaps → `s_ready` tracks `m_ready`, 784 windows total, identical pixel-to-window mapping versus the golden model.
- **Abort:** `start` at row 10, col 7 → one `CLR` cycle with `fifo_rst`=1, counters 0. The next frame produces 784 windows with no stale data.
- **Overflow:** `FIFO_DEPTH`=32, `IMG_W`=32, forced `fifo_full[0]`=1 during a row-0 write → `err_ovf`=1 sticky until `rst`, frame completes. Unforced run → no error.
- **Underflow:** forced `fifo_empty[2]`=1 at row 5 → `err_unf`=1, `err_ovf` stays 0.
